// File: rtl/lm96570_spi_master.sv
// -----------------------------------------------------------------------------
// lm96570_spi_master
//   Serial-interface sequencer for the LM96570 beamformer pulse generator.
//   A start request loads an N-bit word (1 <= N <= MAX_BITS). The word is
//   shifted out LSB-first on spi_sdo/spi_sclk inside a spi_le frame. Read-back
//   bits on spi_sdi are collected into rx_data.
//
// Ports
//   clk, reset_n        system clock, asynchronous active-low reset
//   start               request pulse, sampled only while idle
//   num_of_bits[7:0]    transfer length N, sampled with start
//   tx_data             word to send, bit 0 first, sampled with start
//   busy                high for the whole frame
//   done                1-cycle pulse at the end of a transfer
//   err                 1-cycle pulse when start carries an illegal N
//   rx_data             captured read-back; bits >= N are zero
//   spi_sclk/sdo/le     pins to the device (all registered, idle low)
//   spi_sdi             serial data from the device
// -----------------------------------------------------------------------------
module lm96570_spi_master #(
    parameter int MAX_BITS = 64,
    parameter int CLK_DIV  = 4
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                start,
    input  logic [7:0]          num_of_bits,
    input  logic [MAX_BITS-1:0] tx_data,
    output logic                busy,
    output logic                done,
    output logic                err,
    output logic [MAX_BITS-1:0] rx_data,
    output logic                spi_sclk,
    output logic                spi_sdo,
    input  logic                spi_sdi,
    output logic                spi_le
);

    localparam int IDX_W = (MAX_BITS > 1) ? $clog2(MAX_BITS) : 1;
    localparam int DIV_W = $clog2(CLK_DIV + 1);
    localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(CLK_DIV - 1);
    // The setup phase gets one extra cycle: the cycle right after acceptance
    // already shows le/busy/sdo before the CLK_DIV-long setup window.
    localparam logic [DIV_W-1:0] DIV_FIRST = DIV_W'(CLK_DIV);
    localparam logic [8:0]       MAX_N     = 9'(MAX_BITS);

    typedef enum logic [2:0] {
        S_IDLE, S_SETUP, S_SCLK_HI, S_SCLK_LO, S_LATCH
    } state_t;

    state_t                state_q, state_d;
    logic [DIV_W-1:0]      div_q, div_d;
    logic [7:0]            cnt_q, cnt_d;
    logic [7:0]            n_q, n_d;
    logic [MAX_BITS-1:0]   tx_sh_q, tx_sh_d;
    logic [MAX_BITS-1:0]   rx_acc_q, rx_acc_d;
    logic [MAX_BITS-1:0]   rx_data_q, rx_data_d;
    logic                  sclk_q, sclk_d;
    logic                  sdo_q, sdo_d;
    logic                  le_q, le_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  err_q, err_d;

    logic                  n_legal;
    logic                  phase_end;
    logic [IDX_W-1:0]      rx_idx;

    assign n_legal   = (num_of_bits != 8'd0) && ({1'b0, num_of_bits} <= MAX_N);
    assign phase_end = (div_q == '0);
    // Bit position of the current high phase: counter runs N..1.
    assign rx_idx    = IDX_W'(n_q - cnt_q);

    // State and datapath registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= S_IDLE;
            div_q     <= '0;
            cnt_q     <= '0;
            n_q       <= '0;
            tx_sh_q   <= '0;
            rx_acc_q  <= '0;
            rx_data_q <= '0;
            sclk_q    <= 1'b0;
            sdo_q     <= 1'b0;
            le_q      <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            div_q     <= div_d;
            cnt_q     <= cnt_d;
            n_q       <= n_d;
            tx_sh_q   <= tx_sh_d;
            rx_acc_q  <= rx_acc_d;
            rx_data_q <= rx_data_d;
            sclk_q    <= sclk_d;
            sdo_q     <= sdo_d;
            le_q      <= le_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            err_q     <= err_d;
        end
    end

    // Next-state and datapath update
    always_comb begin
        state_d   = state_q;
        div_d     = div_q;
        cnt_d     = cnt_q;
        n_d       = n_q;
        tx_sh_d   = tx_sh_q;
        rx_acc_d  = rx_acc_q;
        rx_data_d = rx_data_q;

        unique case (state_q)
            S_IDLE: begin
                if (start && n_legal) begin
                    state_d  = S_SETUP;
                    div_d    = DIV_FIRST;
                    cnt_d    = num_of_bits;
                    n_d      = num_of_bits;
                    tx_sh_d  = tx_data;
                    rx_acc_d = '0;
                end
            end
            S_SETUP: begin
                if (phase_end) begin
                    state_d = S_SCLK_HI;
                    div_d   = DIV_LAST;
                end else begin
                    div_d = div_q - 1'b1;
                end
            end
            S_SCLK_HI: begin
                if (phase_end) begin
                    // Capture on the last clk of the high phase, then advance sdo.
                    rx_acc_d[rx_idx] = spi_sdi;
                    tx_sh_d          = tx_sh_q >> 1;
                    cnt_d            = cnt_q - 8'd1;
                    state_d          = S_SCLK_LO;
                    div_d            = DIV_LAST;
                end else begin
                    div_d = div_q - 1'b1;
                end
            end
            S_SCLK_LO: begin
                if (phase_end) begin
                    state_d = (cnt_q == 8'd0) ? S_LATCH : S_SCLK_HI;
                    div_d   = DIV_LAST;
                end else begin
                    div_d = div_q - 1'b1;
                end
            end
            S_LATCH: begin
                if (phase_end) begin
                    state_d   = S_IDLE;
                    rx_data_d = rx_acc_q;
                end else begin
                    div_d = div_q - 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Pin/status outputs, decoded from the next state so they are registered
    always_comb begin
        sclk_d = (state_d == S_SCLK_HI);
        le_d   = (state_d != S_IDLE);
        busy_d = (state_d != S_IDLE);
        sdo_d  = 1'b0;
        if (state_d == S_SETUP || state_d == S_SCLK_HI || state_d == S_SCLK_LO) begin
            sdo_d = tx_sh_d[0];
        end
        done_d = (state_q == S_LATCH) && (state_d == S_IDLE);
        err_d  = (state_q == S_IDLE) && start && !n_legal;
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign err      = err_q;
    assign rx_data  = rx_data_q;
    assign spi_sclk = sclk_q;
    assign spi_sdo  = sdo_q;
    assign spi_le   = le_q;

endmodule

// File: tb/tb_lm96570_spi_master.sv
// Randomized self-checking bench for lm96570_spi_master (MAX_BITS=64, CLK_DIV=2).
// The reference is transaction level: expected sdo bits at each SCLK rise are
// tx bits 0..N-1, expected rx_data is the device pattern (or tx in loopback)
// masked to N bits, and done latency is (2N+2)*CLK_DIV+1 cycles.
module tb_lm96570_spi_master;
    localparam int MAX_BITS = 64;
    localparam int CLK_DIV  = 2;

    logic                clk = 1'b0;
    logic                reset_n = 1'b0;
    logic                start = 1'b0;
    logic [7:0]          num_of_bits = '0;
    logic [MAX_BITS-1:0] tx_data = '0;
    logic                busy, done, err;
    logic [MAX_BITS-1:0] rx_data;
    logic                spi_sclk, spi_sdo, spi_sdi, spi_le;

    logic                loopback = 1'b1;
    logic                dev_sdi = 1'b0;
    logic [MAX_BITS-1:0] dev_pat = '0;
    int                  dev_k = 0;

    assign spi_sdi = loopback ? spi_sdo : dev_sdi;

    lm96570_spi_master #(.MAX_BITS(MAX_BITS), .CLK_DIV(CLK_DIV)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .num_of_bits(num_of_bits),
        .tx_data(tx_data), .busy(busy), .done(done), .err(err), .rx_data(rx_data),
        .spi_sclk(spi_sclk), .spi_sdo(spi_sdo), .spi_sdi(spi_sdi), .spi_le(spi_le)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Pin monitor and device model: record sdo at each SCLK rise, check sdo is
    // stable while SCLK is high, and present the next device bit after each rise.
    logic sclk_prev = 1'b0;
    logic sdo_prev  = 1'b0;
    logic sdo_seq[$];
    int   unstable = 0;

    always @(negedge clk) begin
        if (spi_sclk && !sclk_prev) begin
            sdo_seq.push_back(spi_sdo);
            if (dev_k < MAX_BITS) dev_sdi = dev_pat[dev_k];
            dev_k++;
        end
        if (spi_sclk && sclk_prev && (spi_sdo !== sdo_prev)) unstable++;
        sclk_prev = spi_sclk;
        sdo_prev  = spi_sdo;
    end

    function automatic logic [63:0] mask_n(input int n);
        logic [63:0] m = '0;
        for (int i = 0; i < n && i < 64; i++) m[i] = 1'b1;
        return m;
    endfunction

    // Runs one transfer; caller is #1 after a clk edge. inject>0 fires a
    // competing start at that cycle. b2b skips the trailing idle check so the
    // next transfer starts in the done cycle.
    task automatic do_xfer(input int n, input logic [63:0] tx, input bit lb,
                           input logic [63:0] pat, input int inject, input bit b2b);
        int          lat;
        int          err_seen;
        logic [63:0] got_sdo;
        loopback = lb;
        dev_pat  = pat;
        dev_k    = 0;
        sdo_seq.delete();
        unstable = 0;
        num_of_bits = n[7:0];
        tx_data     = tx;
        start       = 1'b1;
        @(posedge clk); #1;
        start       = 1'b0;
        // Changing inputs while busy must have no effect.
        tx_data     = {$urandom, $urandom};
        num_of_bits = 8'($urandom);
        chk("busy_rise", busy, 1);
        chk("le_rise", spi_le, 1);
        chk("sdo_first", spi_sdo, tx[0]);
        lat = 0;
        err_seen = 0;
        for (int cyc = 1; cyc <= 1000 && lat == 0; cyc++) begin
            if (cyc == inject) begin
                start = 1'b1; tx_data = 64'hFF; num_of_bits = 8'd8;
            end else begin
                start = 1'b0;
            end
            @(posedge clk); #1;
            if (err) err_seen++;
            if (done) lat = cyc;
        end
        start = 1'b0;
        chk("done_latency", lat, (2 * n + 2) * CLK_DIV + 1);
        chk("busy_fall", busy, 0);
        chk("le_fall", spi_le, 0);
        chk("sclk_rises", sdo_seq.size(), n);
        got_sdo = '0;
        for (int i = 0; i < sdo_seq.size() && i < 64; i++) got_sdo[i] = sdo_seq[i];
        chk("sdo_bits", got_sdo, tx & mask_n(n));
        chk("rx_data", rx_data, (lb ? tx : pat) & mask_n(n));
        chk("sdo_stable", unstable, 0);
        chk("no_err_busy", err_seen, 0);
        if (!b2b) begin
            @(posedge clk); #1;
            chk("done_single", done, 0);
        end
    endtask

    task automatic bad_start(input int n);
        logic [63:0] rx_before;
        int          pins;
        rx_before   = rx_data;
        num_of_bits = n[7:0];
        tx_data     = {$urandom, $urandom};
        start       = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk("err_pulse", err, 1);
        chk("err_busy", busy, 0);
        pins = 0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            if (i == 0) chk("err_clear", err, 0);
            if (spi_sclk || spi_le || busy || done) pins++;
        end
        chk("err_no_pins", pins, 0);
        chk("err_rx_hold", rx_data, rx_before);
    endtask

    initial begin
        int rises_seen;
        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_pins", {spi_sclk, spi_sdo, spi_le, busy, done, err}, 0);
        chk("rst_rx", rx_data, 0);
        reset_n = 1'b1;
        @(posedge clk); #1;

        // Directed: N=8, 0xA5 loopback
        do_xfer(8, 64'hA5, 1'b1, 64'h0, 0, 1'b0);
        // Device read-back, N=48
        do_xfer(48, 64'h123456789ABC, 1'b0, 64'hDEADBEEFCAFEF00D, 0, 1'b0);
        // Reset while idle clears rx_data
        reset_n = 1'b0; #1;
        chk("rst_idle_rx", rx_data, 0);
        chk("rst_idle_pins", {spi_sclk, spi_sdo, spi_le, busy, done, err}, 0);
        @(posedge clk); #1;
        reset_n = 1'b1;
        @(posedge clk); #1;
        // Illegal lengths
        do_xfer(5, 64'h15, 1'b1, 64'h0, 0, 1'b0);
        bad_start(0);
        bad_start(65);
        // Start while busy is ignored
        do_xfer(8, 64'h0F, 1'b1, 64'h0, 10, 1'b0);
        // Boundaries N=1 and N=MAX_BITS, back-to-back through the done cycle
        do_xfer(1, 64'h1, 1'b0, 64'h1, 0, 1'b1);
        do_xfer(64, 64'hF0E1D2C3B4A59687, 1'b0, 64'h8000000000000001, 0, 1'b0);

        // Reset after 3 SCLK rises aborts immediately
        sdo_seq.delete();
        loopback = 1'b1;
        num_of_bits = 8'd16; tx_data = 64'hBEEF; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int i = 0; i < 200 && sdo_seq.size() < 3; i++) begin
            @(posedge clk); #1;
        end
        rises_seen = sdo_seq.size();
        chk("abort_rises", rises_seen, 3);
        reset_n = 1'b0; #1;
        chk("abort_pins", {spi_sclk, spi_sdo, spi_le, busy, done, err}, 0);
        repeat (2) @(posedge clk);
        #1;
        chk("abort_no_done", done, 0);
        reset_n = 1'b1;
        @(posedge clk); #1;
        do_xfer(16, 64'h5A3C, 1'b0, 64'h9669, 0, 1'b0);

        // Randomized transfers
        for (int t = 0; t < 14; t++) begin
            int          n;
            logic [63:0] tx, pat;
            n   = $urandom_range(1, MAX_BITS);
            tx  = {$urandom, $urandom};
            pat = {$urandom, $urandom};
            do_xfer(n, tx, 1'($urandom_range(0, 1)), pat, 0, 1'($urandom_range(0, 1)));
            if (($urandom % 4) == 0) bad_start($urandom_range(65, 255));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
